mux_arb_nto1: RTL and testbench

Parametrised N-input, WIDTH-bit registered selector with valid/ready handshakes on every input and on the output. It generalises the multiplier's fixed 4:1 operand mux: fixed-select mode (Sel chooses the channel) or round-robin arbitration mode. Output is registered with one-cycle latency. It sits between operand sources and the sequential multiplier datapath in the MIPS CPU.

---
 rtl/mux_arb_nto1_pkg.sv | 14 +
 rtl/mux_arb_nto1_rr_grant_n.sv | 40 ++++
 rtl/mux_arb_nto1.sv | 134 +++++++++++++
 tb/tb_mux_arb_nto1.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_nto1_pkg.sv
// Shared constants for the N-to-1 registered selector.
// Holds the Mode encodings and the EMPTY/FULL encoding of the output
// register. The top level and the round-robin encoder both import this package.
package mux_arb_nto1_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/mux_arb_nto1_rr_grant_n.sv
// Round-robin priority encoder (module rr_grant_n).
// The encoder scans the channels in the order ptr, ptr+1, ... modulo N and
// grants the first channel that is valid.
//   valid : per-channel request
//   ptr   : channel with the highest priority this cycle
//   grant : one-hot grant, all zero when no channel is valid
//   idx   : index of the granted channel (0 when nothing is granted)
//   any   : at least one channel is granted
module rr_grant_n
    import mux_arb_nto1_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic [N-1:0]    valid,
    input  logic [SELW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [SELW-1:0] idx,
    output logic            any
);

    logic [SELW-1:0] ch;

    // N is a power of two, so SELW-bit addition wraps modulo N by itself.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        ch    = '0;
        for (int k = 0; k < N; k++) begin
            ch = ptr + SELW'(k);
            if (!any && valid[ch]) begin
                any       = 1'b1;
                idx       = ch;
                grant[ch] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nto1.sv
// N-input, WIDTH-bit registered selector with valid/ready on every channel.
// Mode=0 forwards the channel chosen by Sel. Mode=1 arbitrates between the
// valid channels in round-robin order. The output register adds one cycle of
// latency and sustains one word per cycle.
//   Clk, Reset        : rising-edge clock, synchronous active-high reset
//   InData/InValid    : N packed channels (channel i at [i*WIDTH +: WIDTH])
//   InReady           : combinational per-channel ready
//   Mode, Sel, Flush  : arbitration mode, fixed channel, clear of the output register
//   OutData/OutValid  : registered word and its valid flag
//   OutReady          : downstream accept
//   OutSel            : source channel of OutData
module mux_arb_nto1
    import mux_arb_nto1_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int N     = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [N*WIDTH-1:0]   InData,
    input  logic [N-1:0]         InValid,
    output logic [N-1:0]         InReady,
    input  logic                 Mode,
    input  logic [SELW-1:0]      Sel,
    input  logic                 Flush,
    output logic [WIDTH-1:0]     OutData,
    output logic                 OutValid,
    input  logic                 OutReady,
    output logic [SELW-1:0]      OutSel
);

    out_state_e       out_state_q, out_state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, out_sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;

    logic [N-1:0]     rr_grant;
    logic [SELW-1:0]  rr_idx;
    logic             rr_any;

    logic [N-1:0]     fixed_grant;
    logic [N-1:0]     grant;
    logic [SELW-1:0]  g_idx;
    logic             g_any;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] sel_word;

    rr_grant_n #(
        .N    (N),
        .SELW (SELW)
    ) u_rr_grant (
        .valid (InValid),
        .ptr   (ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx),
        .any   (rr_any)
    );

    // Fixed mode grants Sel only, even when other channels are valid.
    always_comb begin
        fixed_grant      = '0;
        fixed_grant[Sel] = InValid[Sel];
    end

    // Select the active grant source. A word is loaded only when the register
    // can take it, and Flush or Reset suppresses the load.
    always_comb begin
        if (Mode == MODE_RR) begin
            grant = rr_grant;
            g_idx = rr_idx;
            g_any = rr_any;
        end else begin
            grant = fixed_grant;
            g_idx = Sel;
            g_any = InValid[Sel];
        end
        can_load = (out_state_q == OUT_EMPTY) || OutReady;
        load     = g_any && can_load && !Flush && !Reset;
        InReady  = grant & {N{can_load && !Flush && !Reset}};
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N; i++) begin
            if (g_idx == SELW'(i)) begin
                sel_word = InData[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next state of the output register. Flush wins over load. A load during an
    // output transfer keeps the register FULL. OutData and OutSel keep their
    // last value when the register empties.
    always_comb begin
        out_state_d = out_state_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (Flush) begin
            out_state_d = OUT_EMPTY;
        end else if (load) begin
            out_state_d = OUT_FULL;
            out_data_d  = sel_word;
            out_sel_d   = g_idx;
            if (Mode == MODE_RR) begin
                ptr_d = g_idx + SELW'(1);
            end
        end else if (OutReady) begin
            out_state_d = OUT_EMPTY;
        end
    end

    // Register update with synchronous reset. Reset discards any held word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_state_q <= OUT_EMPTY;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_state_q <= out_state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign OutValid = (out_state_q == OUT_FULL);
    assign OutData  = out_data_q;
    assign OutSel   = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Directed scoreboard bench for mux_arb_nto1 with N=4 and WIDTH=4.
// The stimulus pushes each word it expects to be loaded. A monitor pops and
// compares that word when the output transfers it. Per-cycle checks cover
// InReady, OutValid and the held register values.
module tb_mux_arb_nto1;

    localparam int W    = 4;
    localparam int N    = 4;
    localparam int SELW = 2;

    logic            Clk;
    logic            Reset;
    logic [N*W-1:0]  InData;
    logic [N-1:0]    InValid;
    logic [N-1:0]    InReady;
    logic            Mode;
    logic [SELW-1:0] Sel;
    logic            Flush;
    logic [W-1:0]    OutData;
    logic            OutValid;
    logic            OutReady;
    logic [SELW-1:0] OutSel;

    logic [SELW+W-1:0] exp_q[$];
    int total;
    int bad;

    mux_arb_nto1 #(
        .WIDTH (W),
        .N     (N)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InData   (InData),
        .InValid  (InValid),
        .InReady  (InReady),
        .Mode     (Mode),
        .Sel      (Sel),
        .Flush    (Flush),
        .OutData  (OutData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutSel   (OutSel)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: drive the inputs, queue the expected load, check
    // InReady and OutValid mid-cycle, then step past the next rising edge.
    task automatic applyStimulus(
        input logic [N-1:0]    v,
        input logic [N*W-1:0]  d,
        input logic            m,
        input logic [SELW-1:0] s,
        input logic            ordy,
        input logic            fl,
        input logic [N-1:0]    exp_rdy,
        input logic            exp_ov,
        input logic            exp_load,
        input logic [W-1:0]    exp_d,
        input logic [SELW-1:0] exp_s
    );
        InValid  = v;
        InData   = d;
        Mode     = m;
        Sel      = s;
        OutReady = ordy;
        Flush    = fl;
        if (exp_load) exp_q.push_back({exp_s, exp_d});
        @(negedge Clk);
        checkOutput("in_ready", 32'(InReady), 32'(exp_rdy));
        checkOutput("out_valid", 32'(OutValid), 32'(exp_ov));
        @(posedge Clk);
        #1;
    endtask

    // Output monitor: compare the word each time the output transfers one.
    always @(negedge Clk) begin
        if (!Reset && OutValid === 1'b1 && OutReady === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL monitor_unexpected: got sel=%0d data=%0h expected none", OutSel, OutData);
            end else begin
                logic [SELW+W-1:0] e;
                e = exp_q.pop_front();
                if ({OutSel, OutData} !== e) begin
                    bad++;
                    $display("[TB] FAIL monitor_word: got sel=%0d data=%0h expected sel=%0d data=%0h",
                             OutSel, OutData, e[SELW+W-1:W], e[W-1:0]);
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        Reset    = 1'b1;
        InData   = 16'hDCBA;
        InValid  = 4'b1111;
        Mode     = 1'b0;
        Sel      = 2'd2;
        Flush    = 1'b0;
        OutReady = 1'b1;

        // Reset values, and InReady held low while Reset is high.
        @(negedge Clk);
        checkOutput("reset_in_ready", 32'(InReady), 32'h0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        checkOutput("reset_out_valid", 32'(OutValid), 32'h0);
        checkOutput("reset_out_data", 32'(OutData), 32'h0);
        checkOutput("reset_out_sel", 32'(OutSel), 32'h0);
        Reset = 1'b0;

        // Fixed mode with Sel=2: channel C on every cycle.
        applyStimulus(4'b1111, 16'hDCBA, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 4'hC, 2'd2);
        for (int i = 0; i < 3; i++)
            applyStimulus(4'b1111, 16'hDCBA, 1'b0, 2'd2, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 4'hC, 2'd2);
        // Sel=1 with channel 1 idle: nothing is granted although others are valid.
        applyStimulus(4'b1101, 16'hDCBA, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 2'd0);

        // Round robin with all channels valid, starting from Ptr=0.
        applyStimulus(4'b1111, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 4'hA, 2'd0);
        applyStimulus(4'b1111, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'hB, 2'd1);
        applyStimulus(4'b1111, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 4'hC, 2'd2);
        applyStimulus(4'b1111, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 4'hD, 2'd3);
        applyStimulus(4'b1111, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 4'hA, 2'd0);
        // Only channels 1 and 3 valid, Ptr=1: the grant alternates 1,3,1,3.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(4'b1010, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'hB, 2'd1);
            applyStimulus(4'b1010, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b1, 1'b1, 4'hD, 2'd3);
        end

        // Backpressure: load 5 from channel 0, then hold for three cycles.
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 4'h5, 2'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 2'd0);
            checkOutput("bp_hold_data", 32'(OutData), 32'h5);
        end
        // OutReady rises: the next word follows with no bubble, and the
        // register reloads and stays FULL while it is emptied.
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'h6, 2'd1);
        applyStimulus(4'b0010, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'h6, 2'd1);

        // Flush while FULL with inputs valid. Ptr=3 afterwards is unchanged.
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0100, 1'b1, 1'b1, 4'h7, 2'd2);
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 4'h0, 2'd0);
        void'(exp_q.pop_back());
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 4'h8, 2'd3);

        // Advance Ptr to 2, then reset with the register FULL.
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b1, 1'b1, 4'h5, 2'd0);
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1, 4'h6, 2'd1);
        Reset = 1'b1;
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 2'd0);
        void'(exp_q.pop_back());
        checkOutput("midreset_out_valid", 32'(OutValid), 32'h0);
        checkOutput("midreset_out_data", 32'(OutData), 32'h0);
        checkOutput("midreset_out_sel", 32'(OutSel), 32'h0);
        Reset = 1'b0;
        applyStimulus(4'b1111, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 4'h5, 2'd0);

        // Drain.
        applyStimulus(4'b0000, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0, 4'h0, 2'd0);
        applyStimulus(4'b0000, 16'h8765, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 4'h0, 2'd0);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
